// File: rtl/apb_rr_sequencer.sv
// Two-requester round-robin APB master.
// Arbitrates, then runs SETUP/ACCESS and returns done/rdata/err.
module apb_rr_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_grant,
  output logic [1:0]        req_done,
  output logic [DATA_W-1:0] req_rdata,
  output logic              req_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sel, tmo;
  logic              psel_d, pen_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic [1:0]        grant_d, done_d;
  logic [DATA_W-1:0] rdata_d;
  logic              err_d;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      req_grant <= '0;
      req_done  <= '0;
      req_rdata <= '0;
      req_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      PSEL      <= psel_d;
      PENABLE   <= pen_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      req_grant <= grant_d;
      req_done  <= done_d;
      req_rdata <= rdata_d;
      req_err   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    psel_d   = PSEL;
    pen_d    = PENABLE;
    pwrite_d = PWRITE;
    paddr_d  = PADDR;
    pwdata_d = PWDATA;
    grant_d  = '0;
    done_d   = '0;
    rdata_d  = '0;
    err_d    = 1'b0;
    // Contention goes to whoever did not finish last.
    sel = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    tmo = (TIMEOUT != 0) &&
          ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT));
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          owner_d  = sel;
          paddr_d  = sel ? req_addr1 : req_addr0;
          pwdata_d = sel ? req_wdata1 : req_wdata0;
          pwrite_d = req_write[sel];
          psel_d   = 1'b1;
          pen_d    = 1'b0;
          grant_d  = sel ? 2'b10 : 2'b01;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY || tmo) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          done_d  = owner_q ? 2'b10 : 2'b01;
          err_d   = ~PREADY;
          rdata_d = (PREADY && !PWRITE) ? PRDATA : '0;
          last_d  = owner_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_rr_sequencer.sv
// Directed bench for apb_rr_sequencer with a memory-backed slave
// and an expected-completion queue.
module tb_apb_rr_sequencer;

  localparam int TMO = 4;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req_valid, req_write;
  logic [31:0] req_addr0, req_wdata0, req_addr1, req_wdata1;
  logic [1:0]  req_grant, req_done;
  logic [31:0] req_rdata;
  logic        req_err;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY;

  apb_rr_sequencer #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr0(req_addr0), .req_wdata0(req_wdata0),
    .req_addr1(req_addr1), .req_wdata1(req_wdata1),
    .req_grant(req_grant), .req_done(req_done),
    .req_rdata(req_rdata), .req_err(req_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Slave: 16-word memory, ready after wait_n ACCESS cycles.
  logic [31:0] mem [16];
  int          wait_n;
  int          acc_cnt;

  assign PRDATA = mem[PADDR[5:2]];
  assign PREADY = PSEL && PENABLE && (acc_cnt >= wait_n);

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE)
      mem[PADDR[5:2]] <= PWDATA;
  end

  typedef struct {
    logic [1:0]  who;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic sb_pop(input string tag);
    exp_t e;
    chk({tag, "_sb_empty"}, 64'(sb_q.size() == 0), 64'd0);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_done"}, 64'(req_done), 64'(e.who));
      chk({tag, "_rdata"}, 64'(req_rdata), 64'(e.rd));
      chk({tag, "_err"}, 64'(req_err), 64'(e.err));
    end
  endtask

  task automatic xfer(input string tag, input int r, input bit wr,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int waits, input logic [31:0] exp_rd,
                      input bit exp_err);
    logic [1:0] oh;
    int acc;
    int exp_acc;
    oh = (r == 1) ? 2'b10 : 2'b01;
    req_valid = oh;
    req_write = wr ? oh : 2'b00;
    if (r == 0) begin req_addr0 = a; req_wdata0 = wd; end
    else begin req_addr1 = a; req_wdata1 = wd; end
    wait_n = waits;
    sb_q.push_back('{oh, exp_rd, exp_err});
    tick();
    chk({tag, "_grant"}, 64'(req_grant), 64'(oh));
    chk({tag, "_psel"}, 64'(PSEL), 64'd1);
    chk({tag, "_pen0"}, 64'(PENABLE), 64'd0);
    chk({tag, "_paddr"}, 64'(PADDR), 64'(a));
    chk({tag, "_pwrite"}, 64'(PWRITE), 64'(wr));
    if (wr) chk({tag, "_pwdata"}, 64'(PWDATA), 64'(wd));
    req_valid = 2'b00;
    req_write = 2'b11;
    req_addr0 = 32'hFFFF_FFF0;
    req_addr1 = 32'hFFFF_FFF0;
    tick();
    acc = 0;
    while (!(|req_done) && acc < 40) begin
      chk({tag, "_acc_psel"}, 64'(PSEL), 64'd1);
      chk({tag, "_acc_pen"}, 64'(PENABLE), 64'd1);
      chk({tag, "_acc_paddr"}, 64'(PADDR), 64'(a));
      chk({tag, "_acc_pwrite"}, 64'(PWRITE), 64'(wr));
      chk({tag, "_acc_grant"}, 64'(req_grant), 64'd0);
      acc++;
      tick();
    end
    exp_acc = (waits + 1 < TMO) ? waits + 1 : TMO;
    chk({tag, "_acc_cycles"}, 64'(acc), 64'(exp_acc));
    sb_pop(tag);
    chk({tag, "_psel_end"}, 64'(PSEL), 64'd0);
    chk({tag, "_pen_end"}, 64'(PENABLE), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcount, dcount, lastc;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000 + i;
    PRESET = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr0 = '0; req_wdata0 = '0;
    req_addr1 = '0; req_wdata1 = '0;
    wait_n = 0;
    tick();
    tick();
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_pen", 64'(PENABLE), 64'd0);
    chk("rst_grant", 64'(req_grant), 64'd0);
    chk("rst_done", 64'(req_done), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_rdata", 64'(req_rdata), 64'd0);
    PRESET = 1'b0;

    // 1: write, 2: read back by other requester
    xfer("t1", 0, 1'b1, 32'h4, 32'd15, 0, 32'd0, 1'b0);
    chk("t1_mem", 64'(mem[1]), 64'd15);
    xfer("t2", 1, 1'b0, 32'h4, 32'd0, 0, 32'd15, 1'b0);

    // 4: slave wait states, 5: timeout, then normal traffic
    xfer("t4", 0, 1'b1, 32'h8, 32'hDEAD_BEEF, 3, 32'd0, 1'b0);
    xfer("t5", 1, 1'b0, 32'hC, 32'd0, 255, 32'd0, 1'b1);
    xfer("t5n", 0, 1'b0, 32'h8, 32'd0, 0, 32'hDEAD_BEEF, 1'b0);

    // 3: both requesters held continuously after reset
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    wait_n = 0;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr0 = 32'h4;
    req_addr1 = 32'h10;
    for (int k = 0; k < 4; k++)
      sb_q.push_back('{(k % 2 == 0) ? 2'b01 : 2'b10,
                       (k % 2 == 0) ? 32'd15 : 32'hA004, 1'b0});
    gcount = 0;
    dcount = 0;
    lastc  = 0;
    for (int c = 0; c < 30 && dcount < 4; c++) begin
      tick();
      chk("t3_grant_onehot", 64'($countones(req_grant) <= 1), 64'd1);
      if (|req_grant) begin
        chk("t3_grant_order", 64'(req_grant),
            (gcount % 2 == 0) ? 64'd1 : 64'd2);
        if (gcount > 0) chk("t3_spacing", 64'(c - lastc), 64'd3);
        lastc = c;
        gcount++;
        if (gcount == 4) req_valid = 2'b00;
      end
      if (|req_done) begin
        sb_pop("t3");
        dcount++;
      end
    end
    chk("t3_grants", 64'(gcount), 64'd4);
    chk("t3_dones", 64'(dcount), 64'd4);

    // 6: reset during ACCESS
    wait_n = 255;
    req_valid = 2'b01;
    req_write = 2'b00;
    req_addr0 = 32'h4;
    tick();
    chk("t6_grant", 64'(req_grant), 64'd1);
    req_valid = 2'b00;
    tick();
    chk("t6_pen", 64'(PENABLE), 64'd1);
    PRESET = 1'b1;
    tick();
    chk("t6_psel", 64'(PSEL), 64'd0);
    chk("t6_pen0", 64'(PENABLE), 64'd0);
    chk("t6_nodone", 64'(req_done), 64'd0);
    PRESET = 1'b0;
    wait_n = 0;
    req_valid = 2'b11;
    req_addr0 = 32'h8;
    req_addr1 = 32'h4;
    sb_q.push_back('{2'b01, 32'hDEAD_BEEF, 1'b0});
    tick();
    chk("t6_first_grant", 64'(req_grant), 64'd1);
    chk("t6_nodone2", 64'(req_done), 64'd0);
    req_valid = 2'b00;
    tick();
    tick();
    sb_pop("t6");
    chk("t6_sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
